// File: rtl/fifo_ptr_pkg.sv
// Gray/binary pointer conversions shared by the write- and read-side FIFO pointer controllers.
// Both work on zero-extended words, so any pointer width up to PTR_MAX_W is handled by casting.
package fifo_ptr_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2grey(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the result exact for narrower pointers.
    function automatic ptr_word_t grey2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/greyptr_wr_ctrl_if.sv
// Write-side FIFO pointer bus between the write requester (master) and the pointer controller (slave).
// Handshake: wr_req is a request held by the master; the slave accepts it in the same cycle by raising
// wr_en combinationally, and a request seen while full is dropped and reported on overflow next cycle.
interface greyptr_wr_ctrl_if #(
    parameter int ADDRWIDTH = 4
);
    logic                 wr_req;
    logic [ADDRWIDTH:0]   rd_ptr_grey_sync;
    logic                 wr_en;
    logic [ADDRWIDTH-1:0] wr_addr;
    logic [ADDRWIDTH:0]   wr_ptr_grey;
    logic                 full;
    logic                 afull;
    logic [ADDRWIDTH:0]   wr_level;
    logic                 overflow;

    modport master (
        output wr_req, rd_ptr_grey_sync,
        input  wr_en, wr_addr, wr_ptr_grey, full, afull, wr_level, overflow
    );

    modport slave (
        input  wr_req, rd_ptr_grey_sync,
        output wr_en, wr_addr, wr_ptr_grey, full, afull, wr_level, overflow
    );
endinterface

// File: rtl/greyptr_reg.sv
// Binary + Gray pointer register pair with increment; the Gray copy is always flop-driven so it can
// cross clock domains one bit at a time.
module greyptr_reg
    import fifo_ptr_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-2:0] o_addr,
    output logic [W-1:0] o_grey,
    output logic [W-1:0] o_bin_next,
    output logic [W-1:0] o_grey_next
);

    logic [W-1:0] r_bin;
    logic [W-1:0] r_grey;

    assign o_bin_next  = r_bin + {{(W-1){1'b0}}, i_inc};
    assign o_grey_next = W'(bin2grey(PTR_MAX_W'(o_bin_next)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_grey <= '0;
        end else begin
            r_bin  <= o_bin_next;
            r_grey <= o_grey_next;
        end
    end

    assign o_addr = r_bin[W-2:0];
    assign o_grey = r_grey;

endmodule

// File: rtl/greyptr_wr_ctrl.sv
// Write-side pointer controller of the dual-clock FIFO: RAM write strobe/address, Gray write pointer
// toward the read domain, and full / almost-full / level flags derived from the synchronized read pointer.
module greyptr_wr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDRWIDTH    = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic               clk_src,
    input  logic               rst_src,
    greyptr_wr_ctrl_if.slave   bus
);

    localparam int PW = ADDRWIDTH + 1;

    logic                 w_wr_en;
    logic [ADDRWIDTH-1:0] w_addr;
    logic [PW-1:0]        w_grey;
    logic [PW-1:0]        w_bin_next;
    logic [PW-1:0]        w_grey_next;
    logic [PW-1:0]        w_rd_bin;
    logic [PW-1:0]        w_full_match;
    logic [PW-1:0]        w_level_next;
    logic                 w_full_next;
    logic                 w_afull_next;

    logic                 r_full;
    logic                 r_afull;
    logic [PW-1:0]        r_level;
    logic                 r_overflow;

    assign w_wr_en = bus.wr_req & ~r_full;

    greyptr_reg #(
        .W (PW)
    ) u_wr_ptr (
        .clk         (clk_src),
        .rst         (rst_src),
        .i_inc       (w_wr_en),
        .o_addr      (w_addr),
        .o_grey      (w_grey),
        .o_bin_next  (w_bin_next),
        .o_grey_next (w_grey_next)
    );

    // Full when the write pointer is one lap ahead: in Gray that is the top two bits inverted.
    assign w_rd_bin     = PW'(grey2bin(PTR_MAX_W'(bus.rd_ptr_grey_sync)));
    assign w_full_match = {~bus.rd_ptr_grey_sync[PW-1:PW-2], bus.rd_ptr_grey_sync[PW-3:0]};
    assign w_full_next  = (w_grey_next == w_full_match);
    assign w_level_next = w_bin_next - w_rd_bin;
    assign w_afull_next = (w_level_next >= PW'(AFULL_THRESH));

    always_ff @(posedge clk_src or posedge rst_src) begin
        if (rst_src) begin
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full     <= w_full_next;
            r_afull    <= w_afull_next;
            r_level    <= w_level_next;
            r_overflow <= bus.wr_req & r_full;
        end
    end

    assign bus.wr_en       = w_wr_en;
    assign bus.wr_addr     = w_addr;
    assign bus.wr_ptr_grey = w_grey;
    assign bus.full        = r_full;
    assign bus.afull       = r_afull;
    assign bus.wr_level    = r_level;
    assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_greyptr_wr_ctrl.sv
// Bench for greyptr_wr_ctrl: two instances (almost-full threshold 12 and 16) share one stimulus stream;
// a count-based FIFO occupancy model feeds an expected queue that a negedge monitor drains.
module tb_greyptr_wr_ctrl;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    greyptr_wr_ctrl_if #(.ADDRWIDTH(AW)) if_a ();
    greyptr_wr_ctrl_if #(.ADDRWIDTH(AW)) if_b ();

    greyptr_wr_ctrl #(.ADDRWIDTH(AW), .AFULL_THRESH(12)) u_dut (
        .clk_src (clk),
        .rst_src (rst),
        .bus     (if_a.slave)
    );

    greyptr_wr_ctrl #(.ADDRWIDTH(AW), .AFULL_THRESH(16)) u_dut_t16 (
        .clk_src (clk),
        .rst_src (rst),
        .bus     (if_b.slave)
    );

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic          acc;
        logic          ovf;
        logic [PW-1:0] grey;
        logic [PW-1:0] level;
        logic          full;
        logic          afull;
        logic          afull_t16;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Model: total writes accepted and total reads seen since reset; occupancy is their difference.
    int m_wr   = 0;
    int m_rd   = 0;
    bit m_full = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    function automatic logic [PW-1:0] gray_of(input int n);
        int m;
        m = n % (2 * DEPTH);
        return PW'(m ^ (m >> 1));
    endfunction

    task automatic drive(input bit req, input int rd_new);
        exp_t e;
        int   lvl;
        bit   acc;
        @(posedge clk);
        #2;
        if_a.wr_req = req;
        if_b.wr_req = req;
        if_a.rd_ptr_grey_sync = gray_of(rd_new);
        if_b.rd_ptr_grey_sync = gray_of(rd_new);
        acc    = req && !m_full;
        e.en   = acc;
        e.acc  = acc;
        e.addr = AW'(m_wr % DEPTH);
        e.ovf  = req && m_full;
        m_wr   = m_wr + (acc ? 1 : 0);
        m_rd   = rd_new;
        lvl    = m_wr - m_rd;
        e.grey      = gray_of(m_wr);
        e.level     = PW'(lvl);
        e.full      = (lvl == DEPTH);
        e.afull     = (lvl >= 12);
        e.afull_t16 = (lvl >= 16);
        m_full = e.full;
        exp_q.push_back(e);
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #2;
        if_a.wr_req = 1'b0;
        if_b.wr_req = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_grey",     int'(if_a.wr_ptr_grey), 0);
        check("rst_full",     int'(if_a.full), 0);
        check("rst_afull",    int'(if_a.afull), 0);
        check("rst_level",    int'(if_a.wr_level), 0);
        check("rst_overflow", int'(if_a.overflow), 0);
        check("rst_addr",     int'(if_a.wr_addr), 0);
        m_wr = 0;
        m_rd = 0;
        m_full = 1'b0;
        if_a.rd_ptr_grey_sync = '0;
        if_b.rd_ptr_grey_sync = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    exp_t          mon_e;
    logic [PW-1:0] mon_g0;

    always @(negedge clk) begin
        if (!rst && exp_q.size() != 0) begin
            mon_e = exp_q[0];
            check("wr_en",   int'(if_a.wr_en), int'(mon_e.en));
            check("wr_addr", int'(if_a.wr_addr), int'(mon_e.addr));
            mon_g0 = if_a.wr_ptr_grey;
            @(posedge clk);
            #1;
            check("wr_ptr_grey",   int'(if_a.wr_ptr_grey), int'(mon_e.grey));
            check("grey_bits_chg", $countones(mon_g0 ^ if_a.wr_ptr_grey), mon_e.acc ? 1 : 0);
            check("full",          int'(if_a.full), int'(mon_e.full));
            check("afull",         int'(if_a.afull), int'(mon_e.afull));
            check("wr_level",      int'(if_a.wr_level), int'(mon_e.level));
            check("overflow",      int'(if_a.overflow), int'(mon_e.ovf));
            check("afull_t16",     int'(if_b.afull), int'(mon_e.afull_t16));
            check("full_t16",      int'(if_b.full), int'(mon_e.full));
            void'(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd_new;
        int lim;
        bit req;

        if_a.wr_req = 1'b1;
        if_b.wr_req = 1'b1;
        if_a.rd_ptr_grey_sync = '0;
        if_b.rd_ptr_grey_sync = '0;
        #3;
        check("init_grey",     int'(if_a.wr_ptr_grey), 0);
        check("init_full",     int'(if_a.full), 0);
        check("init_afull",    int'(if_a.afull), 0);
        check("init_level",    int'(if_a.wr_level), 0);
        check("init_overflow", int'(if_a.overflow), 0);
        check("init_addr",     int'(if_a.wr_addr), 0);
        check("init_wr_en_hi", int'(if_a.wr_en), 1);
        if_a.wr_req = 1'b0;
        if_b.wr_req = 1'b0;
        #1;
        check("init_wr_en_lo", int'(if_a.wr_en), 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill to full with no reads, then hammer the full FIFO.
        for (int i = 0; i < 17; i++) drive(1'b1, 0);
        drive(1'b1, 0);
        drive(1'b0, 0);
        drive(1'b1, 0);

        // Free one slot, then a write refills it; the next request overflows.
        drive(1'b0, 1);
        drive(1'b1, 1);
        drive(1'b1, 1);

        // Drain, then stream with the reader trailing by at most four entries across pointer wraps.
        drive(1'b0, m_wr);
        for (int i = 0; i < 64; i++) begin
            rd_new = (m_wr - 3 > m_rd) ? m_wr - 3 : m_rd;
            drive(1'b1, rd_new);
        end

        // Random writes and read advances.
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 3) != 0);
            lim = m_wr - m_rd;
            if (lim > 2) lim = 2;
            rd_new = m_rd + int'($urandom_range(0, lim));
            drive(req, rd_new);
        end

        // Build level 9 and reset in the middle of the burst.
        drive(1'b0, m_wr);
        for (int i = 0; i < 9; i++) drive(1'b1, m_rd);
        async_reset_check();

        // After reset: fill to 16 so both thresholds and full are exercised from address 0.
        for (int i = 0; i < 16; i++) drive(1'b1, 0);
        drive(1'b1, 0);
        drive(1'b0, 0);

        repeat (2) @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
